// File: rtl/sprite_table_avalon.sv
// Double-buffered sprite attribute table behind an Avalon-MM slave.
// The CPU writes the shadow bank. The display side reads the active bank.
// Shadow is copied to active in one cycle at the frame boundary, and only
// when the CPU has armed a commit. This keeps sprites from tearing mid-frame.
module sprite_table_avalon #(
   parameter int NUM_SPRITES = 20,
   parameter int V_ACTIVE    = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        chipselect,
   input  logic        write,
   input  logic        read,
   input  logic [4:0]  address,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq,
   input  logic [9:0]  VGA_HCOUNT,
   input  logic [9:0]  VGA_VCOUNT,
   input  logic [4:0]  sprite_index,
   output logic [23:0] sprite_entry
);

   localparam logic [4:0] ADDR_CONTROL = 5'd30;
   localparam logic [4:0] ADDR_STATUS  = 5'd31;
   localparam logic [5:0] NUM_ENT      = 6'(NUM_SPRITES);
   localparam logic [9:0] V_END        = 10'(V_ACTIVE);

   // Entry layout: {id[23:19], x[18:10], y[9:0]}. An id of 0 disables the sprite.
   logic [23:0] r_shadow [NUM_SPRITES];
   logic [23:0] r_active [NUM_SPRITES];

   logic        r_pending;
   logic        r_irq;
   logic [7:0]  r_frame_count;
   logic        r_match_d;
   logic [31:0] r_readdata;
   logic [23:0] r_sprite_entry;

   logic        w_wr;
   logic        w_rd;
   logic        w_addr_entry;
   logic        w_entry_wr;
   logic        w_ctrl_wr;
   logic        w_ctrl_set;
   logic        w_ctrl_clr;
   logic        w_match;
   logic        w_frame_evt;
   logic        w_commit;
   logic        w_idx_valid;
   logic [31:0] w_rd_data;
   logic [23:0] w_disp_data;

   assign w_wr         = chipselect & write;
   assign w_rd         = chipselect & read;
   assign w_addr_entry = ({1'b0, address} < NUM_ENT);
   assign w_entry_wr   = w_wr & w_addr_entry;
   assign w_ctrl_wr    = w_wr & (address == ADDR_CONTROL);
   assign w_ctrl_set   = w_ctrl_wr & writedata[0];
   assign w_ctrl_clr   = w_ctrl_wr & writedata[1];

   // The VGA counters arrive already registered. The frame event is the rising
   // edge of the match, so it still gives one pulse per frame when the pixel
   // clock is slower than clk and HCOUNT stays at 0 for several cycles.
   assign w_match     = (VGA_VCOUNT == V_END) && (VGA_HCOUNT == 10'd0);
   assign w_frame_evt = w_match & ~r_match_d;

   // An arming write that lands on the frame event itself defers the commit
   // to the next frame. pending stays set so that commit is not lost.
   assign w_commit = w_frame_evt & r_pending & ~w_ctrl_set;

   assign w_idx_valid = ({1'b0, sprite_index} < NUM_ENT);

   // CPU read mux: shadow entries, STATUS, and zero for everything else.
   always_comb begin
      w_rd_data = '0;
      if (w_addr_entry)
         w_rd_data = {8'h00, r_shadow[address]};
      else if (address == ADDR_STATUS)
         w_rd_data = {22'h0, r_irq, r_pending, r_frame_count};
   end

   // Display lookup into the active bank. Indices past the table return 0.
   always_comb begin
      w_disp_data = '0;
      if (w_idx_valid)
         w_disp_data = r_active[sprite_index];
   end

   // Frame-event edge detector state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_match_d <= 1'b0;
      else       r_match_d <= w_match;
   end

   // Shadow bank: CPU writes only. writedata[31:24] is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_SPRITES; i++) r_shadow[i] <= '0;
      end else if (w_entry_wr) begin
         r_shadow[address] <= writedata[23:0];
      end
   end

   // Active bank: whole-table copy in the commit cycle. The copy reads the
   // pre-edge shadow, so a CPU write in the same cycle waits for the next commit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_SPRITES; i++) r_active[i] <= '0;
      end else if (w_commit) begin
         for (int i = 0; i < NUM_SPRITES; i++) r_active[i] <= r_shadow[i];
      end
   end

   // Commit arming flag: set by CONTROL bit0, consumed by a commit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           r_pending <= 1'b0;
      else if (w_ctrl_set) r_pending <= 1'b1;
      else if (w_commit)   r_pending <= 1'b0;
   end

   // Frame interrupt: a commit sets it and wins over a same-cycle clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           r_irq <= 1'b0;
      else if (w_commit)   r_irq <= 1'b1;
      else if (w_ctrl_clr) r_irq <= 1'b0;
   end

   // Count of committed frames. It wraps at 8 bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         r_frame_count <= 8'd0;
      else if (w_commit) r_frame_count <= r_frame_count + 8'd1;
   end

   // Read data register: loaded on a read, held until the next read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     r_readdata <= '0;
      else if (w_rd) r_readdata <= w_rd_data;
   end

   // Registered display output, updated every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_sprite_entry <= '0;
      else       r_sprite_entry <= w_disp_data;
   end

   assign readdata     = r_readdata;
   assign irq          = r_irq;
   assign sprite_entry = r_sprite_entry;

endmodule

// File: tb/tb_sprite_table_avalon.sv
// Directed bench for sprite_table_avalon. All expected values are hand-derived.
module tb_sprite_table_avalon;

   logic        clk = 1'b0;
   logic        reset;
   logic        chipselect, write, read;
   logic [4:0]  address;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;
   logic [9:0]  VGA_HCOUNT, VGA_VCOUNT;
   logic [4:0]  sprite_index;
   logic [23:0] sprite_entry;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] rv;

   sprite_table_avalon #(.NUM_SPRITES(20), .V_ACTIVE(480)) dut (
      .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
      .read(read), .address(address), .writedata(writedata),
      .readdata(readdata), .irq(irq), .VGA_HCOUNT(VGA_HCOUNT),
      .VGA_VCOUNT(VGA_VCOUNT), .sprite_index(sprite_index),
      .sprite_entry(sprite_entry)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cnt();
      VGA_VCOUNT = 10'd0;
      VGA_HCOUNT = 10'd5;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      tick();
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      chipselect = 1'b1; read = 1'b1; address = a;
      tick();
      chipselect = 1'b0; read = 1'b0;
      d = readdata;
   endtask

   // One frame boundary: the match lasts one cycle, then the counters go idle.
   task automatic frame();
      VGA_VCOUNT = 10'd480; VGA_HCOUNT = 10'd0;
      tick();
      idle_cnt();
      tick();
   endtask

   // Frame boundary together with a CPU write in the same cycle.
   task automatic frame_with_wr(input logic [4:0] a, input logic [31:0] d);
      VGA_VCOUNT = 10'd480; VGA_HCOUNT = 10'd0;
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      tick();
      chipselect = 1'b0; write = 1'b0;
      idle_cnt();
      tick();
   endtask

   task automatic disp(input string tag, input logic [4:0] idx, input logic [23:0] exp);
      sprite_index = idx;
      tick();
      chk(tag, {8'h0, sprite_entry}, {8'h0, exp});
   endtask

   initial begin
      reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
      address = '0; writedata = '0; sprite_index = '0;
      idle_cnt();
      #1;
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      chk("rst_entry", {8'h0, sprite_entry}, 32'h0);
      tick(); tick();
      reset = 1'b0;
      tick();

      // Reset state
      rd(5'd3, rv);  chk("rst_rd_e3", rv, 32'h0);
      rd(5'd31, rv); chk("rst_rd_status", rv, 32'h0);
      for (int i = 0; i < 20; i++) disp($sformatf("rst_disp%0d", i), 5'(i), 24'h0);

      // A write with no commit armed must not reach the display.
      wr(5'd0, 32'h0008_0040);
      frame();
      disp("nocommit_disp0", 5'd0, 24'h0);
      rd(5'd31, rv); chk("nocommit_status", rv, 32'h0);

      // Armed commit
      wr(5'd30, 32'h1);
      frame();
      chk("commit_irq", {31'h0, irq}, 32'h1);
      disp("commit_disp0", 5'd0, 24'h080040);
      rd(5'd31, rv); chk("commit_status", rv, 32'h201);
      wr(5'd30, 32'h2);
      chk("irq_clear", {31'h0, irq}, 32'h0);

      // An entry write in the commit cycle goes to shadow only.
      wr(5'd30, 32'h1);
      frame_with_wr(5'd5, 32'h0012_3456);
      disp("coll_wr_active5", 5'd5, 24'h0);
      rd(5'd5, rv); chk("coll_wr_shadow5", rv, 32'h0012_3456);
      wr(5'd30, 32'h3);
      frame();
      disp("coll_wr_next5", 5'd5, 24'h123456);
      wr(5'd30, 32'h2);

      // Arming in the frame-event cycle defers the commit by one frame.
      wr(5'd1, 32'h000A_BCDE);
      frame_with_wr(5'd30, 32'h1);
      disp("coll_arm_disp1", 5'd1, 24'h0);
      rd(5'd31, rv); chk("coll_arm_status", rv, 32'h103);
      frame();
      disp("coll_arm_next1", 5'd1, 24'h0ABCDE);
      rd(5'd31, rv); chk("coll_arm_status2", rv, 32'h204);

      // An irq clear in the commit cycle loses to the set.
      wr(5'd30, 32'h1);
      frame_with_wr(5'd30, 32'h2);
      chk("coll_clr_irq", {31'h0, irq}, 32'h1);
      rd(5'd31, rv); chk("coll_clr_status", rv, 32'h205);

      // Both CONTROL bits set together.
      wr(5'd30, 32'h3);
      rd(5'd31, rv); chk("ctrl3_status", rv, 32'h105);
      frame();

      // Unused addresses, ignored upper write bits, out-of-range index
      wr(5'd25, 32'hFFFF_FFFF);
      rd(5'd25, rv); chk("unused_rd25", rv, 32'h0);
      rd(5'd30, rv); chk("ctrl_rd", rv, 32'h0);
      rd(5'd31, rv); chk("unused_status", rv, 32'h206);
      disp("idx31", 5'd31, 24'h0);
      disp("idx20", 5'd20, 24'h0);
      wr(5'd2, 32'hFF00_0011);
      rd(5'd2, rv); chk("upper_ignored", rv, 32'h11);

      // frame_count is 6 here; 250 more commits wrap it to 0.
      for (int i = 0; i < 250; i++) begin
         wr(5'd30, 32'h1);
         frame();
      end
      rd(5'd31, rv); chk("fc_wrap", rv, 32'h200);

      // Reset in mid-frame with a commit armed
      wr(5'd30, 32'h1);
      sprite_index = 5'd0;
      tick();
      reset = 1'b1;
      #1;
      chk("midrst_irq", {31'h0, irq}, 32'h0);
      chk("midrst_entry", {8'h0, sprite_entry}, 32'h0);
      tick();
      reset = 1'b0;
      rd(5'd31, rv); chk("midrst_status", rv, 32'h0);
      frame();
      disp("midrst_disp0", 5'd0, 24'h0);
      rd(5'd0, rv); chk("midrst_shadow0", rv, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
